// File: rtl/router_arb_pkg.sv
// Shared types and constants for the router source arbiter.
// Header byte layout: destination address in [1:0], payload length in [7:2].
package router_arb_pkg;

  localparam int DATA_W       = 8;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  typedef struct packed {
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len;
    logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] addr;
  } pkt_hdr_t;

  function automatic pkt_hdr_t hdr_decode(input logic [DATA_W-1:0] b);
    return pkt_hdr_t'(b);
  endfunction

endpackage

// File: rtl/router_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo NUM_SRC. Produces one-hot and binary winner.
module router_rr_picker
  import router_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] win_oh_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      // ptr_i < NUM_SRC, so a single subtraction wraps the search index
      idx = int'(ptr_i) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        win_idx_o     = IDX_W'(idx);
        win_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_src_arbiter.sv
// Round-robin packet arbiter sharing the router input port among NUM_SRC sources.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module router_src_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_SRC-1:0]        src_pkt_valid,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_busy,
  input  logic                      busy,
  output logic                      pkt_valid,
  output logic [DATA_W-1:0]         data_in,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      wdog_timeout
);

  localparam int IDX_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("router_src_arbiter: NUM_SRC must be 2..8 and WDOG_CYCLES >= 1");
  end

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   src_byte [NUM_SRC];

  router_rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (src_pkt_valid),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // grant_q is zero outside GRANT, so every source sees busy=1 while idle
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_byte[i] = src_data[i*DATA_W +: DATA_W];
    assign src_busy[i] = grant_q[i] ? busy : 1'b1;
  end

  assign grant = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_valid = 1'b0;
    data_in   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          rr_ptr_d = (pick_idx == IDX_W'(NUM_SRC-1)) ? '0 : pick_idx + 1'b1;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        pkt_valid = src_pkt_valid[gidx_q];
        data_in   = src_byte[gidx_q];
        // parity byte (valid low) accepted by the router ends the packet
        if (!src_pkt_valid[gidx_q] && !busy) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_to_q, wd_to_d;

  // counts consecutive stalled GRANT cycles; saturates, flag is sticky
  always_comb begin
    wd_cnt_d = '0;
    wd_to_d  = wd_to_q;
    if (state_q == ARB_GRANT && busy) begin
      wd_cnt_d = (wd_cnt_q == WD_W'(WDOG_CYCLES)) ? wd_cnt_q : wd_cnt_q + 1'b1;
      if (wd_cnt_q >= WD_W'(WDOG_CYCLES - 1)) wd_to_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_to_q  <= wd_to_d;
    end
  end

  assign wdog_timeout = wd_to_q;
`else
  assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_src_arbiter.sv
// Randomized self-checking bench: sources hold packet byte queues; a
// protocol-level model tracks the owner, round-robin pointer and stall count.
module tb_router_src_arbiter;

  localparam int NS = 4;
  localparam int WD = 8;

  logic            clock = 1'b0;
  logic            resetn;
  logic [NS-1:0]   src_pkt_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_busy;
  logic            busy;
  logic            pkt_valid;
  logic [7:0]      data_in;
  logic [NS-1:0]   grant;
  logic            wdog_timeout;

  router_src_arbiter #(.NUM_SRC(NS), .WDOG_CYCLES(WD)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .src_pkt_valid (src_pkt_valid),
    .src_data      (src_data),
    .src_busy      (src_busy),
    .busy          (busy),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .grant         (grant),
    .wdog_timeout  (wdog_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // per-source byte queues: bit 8 is the pkt_valid the source drives with the byte
  logic [8:0]    sq [NS][$];
  logic [8:0]    rx [$];
  logic [NS-1:0] glog [$];
  logic          busy_sched [$];
  logic [NS-1:0] prev_grant;
  int            owner, rr, wcnt;
  bit            wflag;
  int            busy_pct;
  bit            rand_src, drop_en;

`ifdef ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int k);
    return (k < rx.size()) ? 32'(rx[k]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] glog_at(input int k);
    return (k < glog.size()) ? 32'(glog[k]) : 32'hDEAD_BEEF;
  endfunction

  task automatic push_pkt(input int s, input logic [5:0] len, input logic [1:0] addr,
                          input logic [31:0] pay);
    logic [7:0] par;
    logic [7:0] b;
    par = {len, addr};
    sq[s].push_back({1'b1, len, addr});
    for (int k = 0; k < int'(len); k++) begin
      b = pay[k*8 +: 8];
      sq[s].push_back({1'b1, b});
      par = par ^ b;
    end
    sq[s].push_back({1'b0, par});
  endtask

  task automatic push_rand(input int s);
    push_pkt(s, 6'($urandom_range(4)), 2'($urandom), $urandom);
  endtask

  task automatic sched(input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) busy_sched.push_back(bits[k]);
  endtask

  task automatic model_reset();
    owner = -1; rr = 0; wcnt = 0; wflag = 1'b0;
    for (int i = 0; i < NS; i++) sq[i].delete();
  endtask

  task automatic cycle();
    logic [NS-1:0] req, eg, esb;
    logic [7:0]    ed;
    logic          ep;
    logic [8:0]    b;
    @(negedge clock);
    if (rand_src)
      for (int i = 0; i < NS; i++)
        if (sq[i].size() == 0 && $urandom_range(3) == 0) push_rand(i);
    busy = (busy_sched.size() > 0) ? busy_sched.pop_front() : ($urandom_range(99) < busy_pct);
    for (int i = 0; i < NS; i++) begin
      bit drop;
      drop = drop_en && (owner != i) && ($urandom_range(7) == 0);
      if (sq[i].size() > 0 && !drop) begin
        src_data[i*8 +: 8] = sq[i][0][7:0];
        req[i] = sq[i][0][8];
      end else begin
        src_data[i*8 +: 8] = 8'($urandom);
        req[i] = 1'b0;
      end
    end
    src_pkt_valid = req;
    #1;
    eg = '0; ed = '0; ep = 1'b0; esb = '1;
    if (owner >= 0) begin
      eg[owner]  = 1'b1;
      ed         = sq[owner][0][7:0];
      ep         = sq[owner][0][8];
      esb[owner] = busy;
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("data_in", 32'(data_in), 32'(ed));
    chk("pkt_valid", 32'(pkt_valid), 32'(ep));
    chk("src_busy", 32'(src_busy), 32'(esb));
    chk("wdog_timeout", 32'(wdog_timeout), 32'(wflag & WD_ON));
    if (grant != '0 && prev_grant == '0) glog.push_back(grant);
    prev_grant = grant;
    if (grant != '0 && !busy) rx.push_back({pkt_valid, data_in});
    // advance the model across the coming rising edge
    if (owner >= 0 && busy) begin
      wcnt++;
      if (wcnt >= WD) wflag = 1'b1;
    end else wcnt = 0;
    if (owner < 0) begin
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (rr + k) % NS;
        if (req[c]) begin
          owner = c;
          rr    = (c + 1) % NS;
          break;
        end
      end
    end else if (!busy) begin
      b = sq[owner].pop_front();
      if (!b[8]) owner = -1;
    end
  endtask

  initial begin
    resetn = 1'b0; busy = 1'b0; src_pkt_valid = '0; src_data = '0;
    busy_pct = 0; rand_src = 1'b0; drop_en = 1'b0; prev_grant = '0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_pkt_valid", 32'(pkt_valid), 32'h0);
    chk("reset_data_in", 32'(data_in), 32'h0);
    chk("reset_src_busy", 32'(src_busy), 32'hF);
    chk("reset_wdog", 32'(wdog_timeout), 32'h0);
    resetn = 1'b1;

    // single packet from source 1: 05, AA, AF
    push_pkt(1, 6'd1, 2'd1, 32'hAA);
    rx.delete(); glog.delete();
    repeat (6) cycle();
    chk("single_grant", glog_at(0), 32'h2);
    chk("single_rx_len", 32'(rx.size()), 32'd3);
    chk("single_rx0", rx_at(0), 32'h105);
    chk("single_rx1", rx_at(1), 32'h1AA);
    chk("single_rx2", rx_at(2), 32'h0AF);

    // async reset while source 1 owns the port
    push_pkt(1, 6'd1, 2'd0, 32'h33);
    repeat (2) cycle();
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_pkt_valid", 32'(pkt_valid), 32'h0);
    chk("rst_mid_src_busy", 32'(src_busy), 32'hF);
    chk("rst_mid_data_in", 32'(data_in), 32'h0);
    model_reset();
    src_pkt_valid = '0;
    @(negedge clock);
    resetn = 1'b1;
    // pointer back at 0: source 0 beats source 3
    push_pkt(0, 6'd0, 2'd0, 32'h0);
    push_pkt(3, 6'd0, 2'd3, 32'h0);
    glog.delete();
    repeat (8) cycle();
    chk("rst_rr_first", glog_at(0), 32'h1);
    chk("rst_rr_second", glog_at(1), 32'h8);

    // all sources requesting continuously
    for (int i = 0; i < NS; i++) begin
      push_pkt(i, 6'd1, 2'(i), 32'h10 + i);
      push_pkt(i, 6'd1, 2'(i), 32'h20 + i);
    end
    glog.delete();
    repeat (40) cycle();
    chk("rr_order0", glog_at(0), 32'h1);
    chk("rr_order1", glog_at(1), 32'h2);
    chk("rr_order2", glog_at(2), 32'h4);
    chk("rr_order3", glog_at(3), 32'h8);
    chk("rr_order4", glog_at(4), 32'h1);

    // back-pressure on the payload byte
    push_pkt(2, 6'd1, 2'd2, 32'h5A);
    rx.delete();
    sched(32'b00011100, 8);
    repeat (8) cycle();
    chk("bp_rx_len", 32'(rx.size()), 32'd3);
    chk("bp_rx0", rx_at(0), 32'h106);
    chk("bp_rx1", rx_at(1), 32'h15A);
    chk("bp_rx2", rx_at(2), 32'h05C);

    // stall on the parity byte
    push_pkt(3, 6'd0, 2'd3, 32'h0);
    rx.delete();
    sched(32'b001100, 6);
    repeat (6) cycle();
    chk("par_rx_len", 32'(rx.size()), 32'd2);
    chk("par_rx0", rx_at(0), 32'h103);
    chk("par_rx1", rx_at(1), 32'h003);

    // watchdog: eight stalled grant cycles
    push_pkt(1, 6'd1, 2'd1, 32'h11);
    sched(32'b0000_1111_1111_00, 14);
    repeat (14) cycle();
    chk("wdog_sticky", 32'(wdog_timeout), 32'(WD_ON));

    // randomized traffic with request drops and random back-pressure
    busy_pct = 30; rand_src = 1'b1; drop_en = 1'b1;
    repeat (3000) cycle();
    busy_pct = 0; rand_src = 1'b0; drop_en = 1'b0;
    repeat (80) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
